clk_div_multi: RTL and testbench

//  N-channel programmable clock divider / tick generator; successor to the single-channel fixed-frequency divider.

---
 rtl/clk_div_multi_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 63 ++++++
 rtl/clk_div_multi.sv | 46 ++++
 tb/tb_clk_div_multi.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel clock divider.
package clk_div_multi_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 12_000_000;

  // Half-period in system clock cycles for a requested output frequency.
  function automatic int unsigned half_period(input int unsigned clk_freq,
                                              input int unsigned freq);
    return clk_freq / freq / 2;
  endfunction

  // Channel index width; one spare bit so out-of-range indices are representable.
  function automatic int unsigned chan_idx_w(input int unsigned channels);
    return $clog2(channels) + 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow half-period pair, 50% duty toggle
// and a one-cycle tick on each rising output edge.
module clk_div_chan #(
  parameter int unsigned        WIDTH        = 32,
  parameter logic [WIDTH-1:0]   DEFAULT_HALF = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  output logic             dividedClk,
  output logic             dividedPulse
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             terminal;

  // >= rather than == so a count left above a shorter half-period cannot run away.
  assign terminal = (count >= (active - ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= DEFAULT_HALF;
    end else if (load) begin
      shadow <= (loadData == '0) ? ONE : loadData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      active       <= DEFAULT_HALF;
      dividedClk   <= 1'b0;
      dividedPulse <= 1'b0;
    end else if (sync) begin
      count        <= '0;
      active       <= shadow;
      dividedClk   <= 1'b0;
      dividedPulse <= 1'b0;
    end else if (enable) begin
      if (terminal) begin
        count        <= '0;
        active       <= shadow;
        dividedClk   <= ~dividedClk;
        dividedPulse <= ~dividedClk;
      end else begin
        count        <= count + ONE;
        dividedPulse <= 1'b0;
      end
    end else begin
      // Idle channels track the shadow so a retune takes effect on re-enable.
      active       <= shadow;
      dividedPulse <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick generator with runtime
// half-period writes and a global phase-realign input.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned  CHANNELS     = 4,
  parameter int unsigned  WIDTH        = 32,
  parameter int unsigned  CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int unsigned  DEFAULT_FREQ = 1,
  localparam int unsigned CHAN_W       = chan_idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  input  logic                wrEn,
  input  logic [CHAN_W-1:0]   wrChan,
  input  logic [WIDTH-1:0]    wrData,
  output logic [CHANNELS-1:0] dividedClk,
  output logic [CHANNELS-1:0] dividedPulse
);

  localparam logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(half_period(CLK_FREQ, DEFAULT_FREQ));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic load;

    // Indices at or above CHANNELS match no channel and are dropped.
    assign load = wrEn && (wrChan == CHAN_W'(i));

    clk_div_chan #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable[i]),
      .sync         (sync),
      .load         (load),
      .loadData     (wrData),
      .dividedClk   (dividedClk[i]),
      .dividedPulse (dividedPulse[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: CLK_FREQ=1000, DEFAULT_FREQ=100 (half-period 5), 4 channels.
module tb_clk_div_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  enable;
  logic        sync;
  logic        wrEn;
  logic [2:0]  wrChan;
  logic [31:0] wrData;
  logic [3:0]  dividedClk;
  logic [3:0]  dividedPulse;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .CHANNELS     (4),
    .WIDTH        (32),
    .CLK_FREQ     (1000),
    .DEFAULT_FREQ (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sync         (sync),
    .wrEn         (wrEn),
    .wrChan       (wrChan),
    .wrData       (wrData),
    .dividedClk   (dividedClk),
    .dividedPulse (dividedPulse)
  );

  typedef struct {
    int          n;
    logic [3:0]  en;
    logic        we;
    logic [2:0]  wch;
    logic [31:0] wd;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input int n, input logic we, input logic [2:0] wch,
                     input logic [31:0] wd, input logic [3:0] ec, input logic [3:0] ep);
    vec_t v;
    v.n = n; v.en = 4'hF; v.we = we; v.wch = wch; v.wd = wd;
    v.exp_clk = ec; v.exp_pulse = ep;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; enable = 4'h0; sync = 1'b0; wrEn = 1'b0; wrChan = '0; wrData = '0;
    #1;
    check("reset_clk", dividedClk, 4'h0);
    check("reset_pulse", dividedPulse, 4'h0);
    repeat (3) tick();
    check("reset_hold_clk", dividedClk, 4'h0);
    rst = 1'b1; enable = 4'hF;

    // Rows: edges since release, all enabled; ch1<-2 at edge 11, ch2<-0 at 26, ch7 (invalid) at 27.
    row(4, 0, 0, 0, 4'b0000, 4'b0000);  // 4
    row(1, 0, 0, 0, 4'b1111, 4'b1111);  // 5: first rise
    row(4, 0, 0, 0, 4'b1111, 4'b0000);  // 9
    row(1, 0, 0, 0, 4'b0000, 4'b0000);  // 10: fall
    row(1, 1, 1, 2, 4'b0000, 4'b0000);  // 11: write ch1=2 mid half
    row(3, 0, 0, 0, 4'b0000, 4'b0000);  // 14
    row(1, 0, 0, 0, 4'b1111, 4'b1111);  // 15
    row(1, 0, 0, 0, 4'b1111, 4'b0000);  // 16
    row(1, 0, 0, 0, 4'b1101, 4'b0000);  // 17: ch1 now half 2
    row(1, 0, 0, 0, 4'b1101, 4'b0000);  // 18
    row(1, 0, 0, 0, 4'b1111, 4'b0010);  // 19
    row(1, 0, 0, 0, 4'b0010, 4'b0000);  // 20
    row(1, 0, 0, 0, 4'b0000, 4'b0000);  // 21
    row(1, 0, 0, 0, 4'b0000, 4'b0000);  // 22
    row(1, 0, 0, 0, 4'b0010, 4'b0010);  // 23
    row(1, 0, 0, 0, 4'b0010, 4'b0000);  // 24
    row(1, 0, 0, 0, 4'b1101, 4'b1101);  // 25
    row(1, 1, 2, 0, 4'b1101, 4'b0000);  // 26: write ch2=0
    row(1, 1, 7, 3, 4'b1111, 4'b0010);  // 27: out-of-range write
    row(1, 0, 0, 0, 4'b1111, 4'b0000);  // 28
    row(1, 0, 0, 0, 4'b1101, 4'b0000);  // 29
    row(1, 0, 0, 0, 4'b0000, 4'b0000);  // 30: ch2 picks up half 1
    row(1, 0, 0, 0, 4'b0110, 4'b0110);  // 31
    row(1, 0, 0, 0, 4'b0010, 4'b0000);  // 32
    row(1, 0, 0, 0, 4'b0100, 4'b0100);  // 33
    row(1, 0, 0, 0, 4'b0000, 4'b0000);  // 34
    row(1, 0, 0, 0, 4'b1111, 4'b1111);  // 35
    row(1, 0, 0, 0, 4'b1011, 4'b0000);  // 36

    for (int r = 0; r < tbl.size(); r++) begin
      enable = tbl[r].en; wrEn = tbl[r].we; wrChan = tbl[r].wch; wrData = tbl[r].wd;
      for (int k = 0; k < tbl[r].n; k++) begin
        tick();
        wrEn = 1'b0;
      end
      check($sformatf("row%0d_clk", r), dividedClk, tbl[r].exp_clk);
      check($sformatf("row%0d_pulse", r), dividedPulse, tbl[r].exp_pulse);
    end

    // Async reset between edges while outputs are high; writes must be discarded.
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_clk", dividedClk, 4'h0);
    check("async_rst_pulse", dividedPulse, 4'h0);
    tick();
    rst = 1'b1; enable = 4'hF;
    repeat (4) tick();
    check("post_rst_edge4_clk", dividedClk, 4'h0);
    tick();
    check("post_rst_edge5_clk", dividedClk, 4'hF);
    check("post_rst_edge5_pulse", dividedPulse, 4'hF);

    // Freeze ch0 at count 2 for 7 cycles, then resume: it needs exactly 3 more edges.
    repeat (2) tick();
    enable = 4'b1110;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("freeze%0d_clk0", k), {3'b000, dividedClk[0]}, 4'b0001);
      check($sformatf("freeze%0d_pulse0", k), {3'b000, dividedPulse[0]}, 4'b0000);
    end
    check("freeze_end_clk", dividedClk, 4'b0001);
    enable = 4'hF;
    tick();
    check("resume1_clk", dividedClk, 4'b1111);
    check("resume1_pulse", dividedPulse, 4'b1110);
    tick();
    check("resume2_clk", dividedClk, 4'b1111);
    tick();
    check("resume3_clk", dividedClk, 4'b1110);
    check("resume3_pulse", dividedPulse, 4'b0000);

    // Sync with ch0 low and the rest high; ch3 disabled during sync.
    sync = 1'b1; enable = 4'b0111;
    tick();
    sync = 1'b0; enable = 4'hF;
    check("sync_clk", dividedClk, 4'h0);
    check("sync_pulse", dividedPulse, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_sync%0d_clk", k + 1), dividedClk, 4'h0);
    end
    tick();
    check("post_sync5_clk", dividedClk, 4'hF);
    check("post_sync5_pulse", dividedPulse, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
